// File: rtl/float_mul_share_arb_pkg.sv
// Shared constants and types for the shared fp32 multiplier arbiter.
package float_mul_share_arb_pkg;

    localparam int FP_W = 32;
    localparam int RM_W = 3;
    localparam int ID_W = 3;

    typedef enum logic [RM_W-1:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    // id is sized for the largest supported NREQ (8); narrower configs use the low bits
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } trk_entry_t;

endpackage

// File: rtl/float_mul_share_arb_if.sv
// Requester-side and result-side handshake bundle of the shared multiplier.
interface float_mul_share_arb_if
    import float_mul_share_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic [NREQ*RM_W-1:0] req_rm;
    logic                 res_valid;
    logic                 res_ready;
    logic [FP_W-1:0]      res_data;
    logic [IDW-1:0]       res_id;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, req_rm, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_rm, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );

endinterface

// File: rtl/float_mul_pipe.sv
// IEEE fp32 multiplier (denormals, specials, 5 rounding modes) with LAT enabled stages.
module float_mul_pipe
    import float_mul_share_arb_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic            clk_i,
    input  logic            astall_i,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    input  logic [RM_W-1:0] rm_i,
    output logic [FP_W-1:0] p_o
);

    logic               sign;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [7:0]         ea, eb;
    logic [23:0]        sig_a, sig_b;
    logic [47:0]        prod, prod_n;
    logic [5:0]         lz;
    logic signed [10:0] be, shamt;
    logic [6:0]         rsh;
    logic [95:0]        wide;
    logic [23:0]        sig;
    logic               grd, stk, inc, ovf;
    logic [24:0]        sig_r;
    logic [8:0]         e_out;
    logic [22:0]        man;
    logic [FP_W-1:0]    res_d;
    logic [FP_W-1:0]    stage_q [LAT];

    assign sign   = a_i[31] ^ b_i[31];
    assign a_zero = (a_i[30:0] == 31'd0);
    assign b_zero = (b_i[30:0] == 31'd0);
    assign a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    assign b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);
    assign a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    assign b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    assign ea     = (a_i[30:23] == 8'd0) ? 8'd1 : a_i[30:23];
    assign eb     = (b_i[30:23] == 8'd0) ? 8'd1 : b_i[30:23];
    assign sig_a  = {a_i[30:23] != 8'd0, a_i[22:0]};
    assign sig_b  = {b_i[30:23] != 8'd0, b_i[22:0]};
    assign prod   = 48'(sig_a) * 48'(sig_b);

    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            if (prod[i]) lz = 6'(47 - i);
        end
    end

    // Normalise to bit 47, then shift further right into the denormal frame when the exponent underflows
    always_comb begin
        prod_n = prod << lz;
        be     = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd126 - $signed({5'b0, lz});
        shamt  = 11'sd1 - be;
        rsh    = '0;
        if (be < 11'sd1) rsh = (shamt > 11'sd49) ? 7'd49 : shamt[6:0];
        wide = {prod_n, 48'd0} >> rsh;
        sig  = wide[95:72];
        grd  = wide[71];
        stk  = |wide[70:0];
        case (rm_e'(rm_i))
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (grd | stk) & sign;
            RM_RUP:  inc = (grd | stk) & ~sign;
            RM_RMM:  inc = grd;
            default: inc = grd & (stk | sig[0]);
        endcase
        sig_r = {1'b0, sig} + {24'd0, inc};
        if (be >= 11'sd1) begin
            e_out = be[8:0] + {8'd0, sig_r[24]};
            man   = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
        end else begin
            e_out = {8'd0, sig_r[23]};
            man   = sig_r[22:0];
        end
        ovf = (e_out >= 9'd255);
    end

    always_comb begin
        res_d = {sign, e_out[7:0], man};
        if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
            res_d = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            res_d = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res_d = {sign, 31'd0};
        end else if (ovf) begin
            case (rm_e'(rm_i))
                RM_RTZ:  res_d = {sign, 8'hFE, 23'h7FFFFF};
                RM_RDN:  res_d = sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
                RM_RUP:  res_d = sign ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
                default: res_d = {sign, 8'hFF, 23'd0};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!astall_i) begin
            stage_q[0] <= res_d;
            for (int unsigned i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign p_o = stage_q[LAT-1];

endmodule

// File: rtl/float_mul_share_arb.sv
// Round-robin arbiter sharing one pipelined fp32 multiplier among NREQ requesters,
// with an id tracker that advances in lockstep with the multiplier.
module float_mul_share_arb
    import float_mul_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                  aclk,
    input  logic                  areset,
    float_mul_share_arb_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    trk_entry_t      trk_q [LAT];
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            stall;
    logic            hit, gnt;
    logic [ID_W-1:0] gnt_idx;
    logic [NREQ-1:0] gnt_oh;
    logic [FP_W-1:0] op_a, op_b, mul_p;
    logic [RM_W-1:0] op_rm;
    logic            busy_w;
    logic            unused_id;

    assign stall = trk_q[LAT-1].valid & ~bus.res_ready;

    // Search from the pointer upward first, then wrap to the low indices
    always_comb begin
        hit     = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!hit && bus.req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                hit     = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!hit && bus.req_valid[i]) begin
                hit     = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        gnt = hit & ~stall & ~areset;
    end

    always_comb begin
        gnt_oh = '0;
        op_a   = '0;
        op_b   = '0;
        op_rm  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt && (gnt_idx == ID_W'(i))) begin
                gnt_oh[i] = 1'b1;
                op_a      = bus.req_a[i*FP_W +: FP_W];
                op_b      = bus.req_b[i*FP_W +: FP_W];
                op_rm     = bus.req_rm[i*RM_W +: RM_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt) ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) trk_q[i] <= '0;
        end else if (!stall) begin
            ptr_q          <= ptr_d;
            trk_q[0].valid <= gnt;
            trk_q[0].id    <= gnt_idx;
            for (int unsigned i = 1; i < LAT; i++) trk_q[i] <= trk_q[i-1];
        end
    end

    float_mul_pipe #(
        .LAT (LAT)
    ) u_mul (
        .clk_i    (aclk),
        .astall_i (stall),
        .a_i      (op_a),
        .b_i      (op_b),
        .rm_i     (op_rm),
        .p_o      (mul_p)
    );

    always_comb begin
        busy_w = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) busy_w = busy_w | trk_q[i].valid;
    end

    assign unused_id     = ^trk_q[LAT-1].id;
    assign bus.req_ready = gnt_oh;
    assign bus.res_valid = trk_q[LAT-1].valid;
    assign bus.res_data  = mul_p;
    assign bus.res_id    = trk_q[LAT-1].id[IDW-1:0];
    assign bus.busy      = busy_w;

endmodule

// File: tb/tb_float_mul_share_arb.sv
// Directed bench for float_mul_share_arb: single-op vector table plus multi-cycle sequences.
module tb_float_mul_share_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    typedef struct {
        int unsigned id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] exp;
    } vec_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;

    float_mul_share_arb_if #(.NREQ(NREQ)) bus ();

    float_mul_share_arb #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    vec_t        vecs [16];
    logic [31:0] st_a [4];
    logic [31:0] st_p [4];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_rm    = '0;
    endtask

    task automatic set_op(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rm);
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
        bus.req_rm[id*3 +: 3]  = rm;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rv;
        int unsigned mptr, eidx, gap, max_gap;
        bit          found;

        vecs[0]  = '{0, 32'h40000000, 32'h40400000, 3'd0, 32'h40C00000};
        vecs[1]  = '{1, 32'h3F800000, 32'hBFC00000, 3'd0, 32'hBFC00000};
        vecs[2]  = '{2, 32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000};
        vecs[3]  = '{3, 32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000};
        vecs[4]  = '{0, 32'h00000000, 32'hC0A00000, 3'd0, 32'h80000000};
        vecs[5]  = '{1, 32'h00000001, 32'h40000000, 3'd0, 32'h00000002};
        vecs[6]  = '{2, 32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000};
        vecs[7]  = '{3, 32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF};
        vecs[8]  = '{0, 32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000};
        vecs[9]  = '{1, 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002};
        vecs[10] = '{2, 32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003};
        vecs[11] = '{3, 32'h3FC00000, 32'h3F800001, 3'd0, 32'h3FC00002};
        vecs[12] = '{0, 32'h3FC00000, 32'h3F800001, 3'd1, 32'h3FC00001};
        vecs[13] = '{1, 32'hBFC00000, 32'h3F800001, 3'd2, 32'hBFC00002};
        vecs[14] = '{2, 32'hBFC00000, 32'h3F800001, 3'd3, 32'hBFC00001};
        vecs[15] = '{3, 32'h00800000, 32'h3F000000, 3'd0, 32'h00400000};
        st_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        st_p = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

        // Reset state, with requests pending during reset
        clear_inputs();
        bus.res_ready = 1'b1;
        bus.req_valid = '1;
        areset = 1'b1;
        tick();
        sample();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        tick();
        clear_inputs();
        areset = 1'b0;

        // Single-op vector table
        do_reset();
        for (int k = 0; k < 16; k++) begin
            clear_inputs();
            set_op(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].rm);
            bus.req_valid = NREQ'(1) << vecs[k].id;
            sample();
            chk($sformatf("vec%0d_ready", k), 32'(bus.req_ready), 32'(NREQ'(1) << vecs[k].id));
            tick();
            bus.req_valid = '0;
            tick();
            sample();
            chk($sformatf("vec%0d_early", k), 32'(bus.res_valid), 32'h0);
            tick();
            sample();
            chk($sformatf("vec%0d_valid", k), 32'(bus.res_valid), 32'h1);
            chk($sformatf("vec%0d_data", k), bus.res_data, vecs[k].exp);
            chk($sformatf("vec%0d_id", k), 32'(bus.res_id), 32'(vecs[k].id));
            tick();
        end

        // All requesters valid continuously: one grant per cycle in RR order
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, st_a[i], 32'h40000000, 3'd0);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            sample();
            chk($sformatf("stream%0d_ready", c), 32'(bus.req_ready), 32'(1) << (c % 4));
            if (c >= 3) begin
                chk($sformatf("stream%0d_valid", c), 32'(bus.res_valid), 32'h1);
                chk($sformatf("stream%0d_id", c), 32'(bus.res_id), 32'((c - 3) % 4));
                chk($sformatf("stream%0d_data", c), bus.res_data, st_p[(c - 3) % 4]);
            end else begin
                chk($sformatf("stream%0d_valid", c), 32'(bus.res_valid), 32'h0);
            end
            tick();
        end
        bus.req_valid = '0;
        repeat (4) tick();

        // Backpressure: three ops, output held for five cycles
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, st_a[i], 32'h40000000, 3'd0);
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'(1) << c);
            tick();
        end
        for (int c = 3; c < 8; c++) begin
            bus.req_valid = 4'hF;
            sample();
            chk($sformatf("bp%0d_valid", c), 32'(bus.res_valid), 32'h1);
            chk($sformatf("bp%0d_data", c), bus.res_data, st_p[0]);
            chk($sformatf("bp%0d_id", c), 32'(bus.res_id), 32'h0);
            chk($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'h0);
            chk($sformatf("bp%0d_busy", c), 32'(bus.busy), 32'h1);
            tick();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int c = 8; c < 11; c++) begin
            sample();
            chk($sformatf("bp%0d_valid", c), 32'(bus.res_valid), 32'h1);
            chk($sformatf("bp%0d_id", c), 32'(bus.res_id), 32'(c - 8));
            chk($sformatf("bp%0d_data", c), bus.res_data, st_p[c - 8]);
            tick();
        end
        sample();
        chk("bp_drain_valid", 32'(bus.res_valid), 32'h0);
        chk("bp_drain_busy", 32'(bus.busy), 32'h0);
        tick();

        // Reset with two ops in flight
        do_reset();
        set_op(0, st_a[0], 32'h40000000, 3'd0);
        set_op(1, st_a[1], 32'h40000000, 3'd0);
        bus.req_valid = 4'b0001;
        sample();
        chk("mid_ready0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0010;
        sample();
        chk("mid_ready1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        sample();
        chk("mid_rst_valid", 32'(bus.res_valid), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            sample();
            chk($sformatf("mid_stale%0d", c), 32'(bus.res_valid), 32'h0);
            tick();
        end

        // First grant in the first cycle after reset deasserts
        set_op(2, 32'h40400000, 32'h40400000, 3'd0);
        bus.req_valid = 4'b0100;
        areset = 1'b1;
        sample();
        chk("first_in_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        areset = 1'b0;
        sample();
        chk("first_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        tick();
        sample();
        chk("first_early", 32'(bus.res_valid), 32'h0);
        tick();
        sample();
        chk("first_valid", 32'(bus.res_valid), 32'h1);
        chk("first_id", 32'(bus.res_id), 32'h2);
        chk("first_data", bus.res_data, 32'h41100000);
        tick();

        // Sparse: requester 2 every third cycle
        do_reset();
        bus.res_ready = 1'b1;
        set_op(2, 32'h40400000, 32'h40400000, 3'd0);
        for (int c = 0; c < 15; c++) begin
            bus.req_valid = ((c % 3) == 0 && c < 12) ? 4'b0100 : 4'b0000;
            sample();
            chk($sformatf("sp%0d_ready", c), 32'(bus.req_ready), 32'(bus.req_valid));
            if (c >= 3 && (c % 3) == 0 && c <= 12) begin
                chk($sformatf("sp%0d_valid", c), 32'(bus.res_valid), 32'h1);
                chk($sformatf("sp%0d_id", c), 32'(bus.res_id), 32'h2);
                chk($sformatf("sp%0d_data", c), bus.res_data, 32'h41100000);
            end else begin
                chk($sformatf("sp%0d_valid", c), 32'(bus.res_valid), 32'h0);
            end
            chk($sformatf("sp%0d_busy", c), 32'(bus.busy), (c >= 1 && c <= 12) ? 32'h1 : 32'h0);
            tick();
        end

        // Fairness: requester 0 held, others random; RR reference model
        do_reset();
        bus.res_ready = 1'b1;
        mptr    = 0;
        gap     = 0;
        max_gap = 0;
        for (int c = 0; c < 40; c++) begin
            rv = {3'($urandom_range(7)), 1'b1};
            bus.req_valid = rv;
            found = 1'b0;
            eidx  = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && rv[(mptr + k) % 4]) begin
                    found = 1'b1;
                    eidx  = (mptr + k) % 4;
                end
            end
            mptr = (eidx + 1) % 4;
            sample();
            chk($sformatf("fair%0d_ready", c), 32'(bus.req_ready), 32'(1) << eidx);
            if (bus.req_ready[0]) gap = 0;
            else gap++;
            if (gap > max_gap) max_gap = gap;
            tick();
        end
        chk("fair_max_gap_le3", 32'(max_gap <= 3), 32'h1);
        bus.req_valid = '0;
        repeat (4) tick();
        sample();
        chk("final_busy", 32'(bus.busy), 32'h0);
        chk("final_valid", 32'(bus.res_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/float_mul_share_arb.md
FLOAT_MUL_SHARE_ARB -- requirements
Module: float_mul_share_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: LAT, 3, multiplier pipeline latency in enabled cycles.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: aclk  in  1  clock, all state on rising edge.
REQ-005 Port: areset  in  1  synchronous active-high reset.
REQ-006 Port: req_valid  in  NREQ  per-requester operand valid.
REQ-007 Port: req_ready  out  NREQ  per-requester operand accepted this cycle.
REQ-008 Port: req_a, req_b  in  NREQ*32 each  packed IEEE fp32 operands, requester i at bits [32i+31:32i].
REQ-009 Port: req_rm  in  NREQ*3  per-requester rounding mode.
REQ-010 Port: res_valid  out  1  result available.
REQ-011 Port: res_ready  in  1  downstream accepts result.
REQ-012 Port: res_data  out  32  fp32 product.
REQ-013 Port: res_id  out  clog2(NREQ)  index of the originating requester.
REQ-014 Port: busy  out  1  any issued operation not yet delivered.

Function
REQ-015 The block SHALL share one pipelined fp32 multiplier among NREQ requesters.
REQ-016 Arbitration SHALL be round-robin: the pointer starts at 0; after a grant to i, the pointer moves to (i+1) mod NREQ.
REQ-017 At most one req_ready bit SHALL be high per cycle, only to a requester with req_valid high, and only when the pipeline is not stalled.
REQ-018 A transfer SHALL occur when req_valid[i] & req_ready[i]; operands and rm of i SHALL be presented to the multiplier in that same cycle.
REQ-019 A tracking shift register of LAT entries {valid, id} SHALL advance in lockstep with the multiplier enable.
REQ-020 Stall (multiplier astall) SHALL equal res_valid & ~res_ready; while stalled, neither the multiplier nor the tracker advances, and no grant is issued.
REQ-021 res_valid SHALL equal the tracker output-entry valid; res_data and res_id SHALL stay stable while res_valid & ~res_ready.
REQ-022 Unstalled latency from transfer to res_valid SHALL be exactly LAT cycles; throughput SHALL be one operation per cycle.
REQ-023 Results SHALL be delivered in issue order; none SHALL be dropped or duplicated.
REQ-024 Bubbles (no grant) SHALL enter the tracker as valid=0 and never produce res_valid.
REQ-025 busy SHALL be the OR of all tracker valid bits.
REQ-026 A requester holding req_valid SHALL be granted within NREQ unstalled cycles.
REQ-027 Arithmetic (rounding, specials, denormals) SHALL be that of the shared multiplier, unmodified.

Reset
REQ-028 On areset: tracker valids 0, RR pointer 0, req_ready 0, res_valid 0, busy 0; res_data and res_id are don't-care.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no res_valid appears for them after reset deasserts.
REQ-030 The first grant SHALL be possible in the first cycle after areset deasserts.

Structure
REQ-031 A shared package SHALL hold the fp32 width constant (32), the rm width (3), and the tracker entry typedef {valid, id}.
REQ-032 The pipelined fp32 multiplier SHALL be the single sub-module (float_mul_pipe), with stall driven per REQ-020.
REQ-033 The arbiter, tracker and stall logic SHALL be in this module; the tracker SHALL be registers, not RAM.

Verification
REQ-034 Single op: req 0 a=0x40000000, b=0x40400000, rm=0 -> after 3 cycles res_valid=1, res_data=0x40C00000, res_id=0.
REQ-035 All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0... one per cycle; res_id sequence matches the grant order after 3 cycles.
REQ-036 Backpressure: issue 3 ops back-to-back, res_ready=0 for 5 cycles -> res_valid held with stable data, req_ready all 0; after release, 3 results in order, no loss.
REQ-037 areset asserted with 2 ops in flight -> res_valid=0 and busy=0 the next cycle; no stale results afterwards.
REQ-038 Sparse requests (req 2 only, every 3rd cycle) -> bubbles give no res_valid; each result is 3 cycles after its grant; busy deasserts after the last result.
REQ-039 Fairness: req 0 held valid while reqs 1-3 toggle randomly -> req 0 granted at least once per 4 unstalled cycles.
